// File: rtl/alu_control_pkg.sv
// Shared definitions for the ALU sequencer and the 16-bit ALU it drives.
// Holds the opcode constants, the sequencer state encoding, the default
// datapath width and a small opcode-classification helper.
package alu_control_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned OP_W  = 5;

    // Opcodes understood by the ALU; anything above ALU_DEC is rejected.
    localparam logic [OP_W-1:0] ALU_ADD = 5'd0;  // add with stored carry
    localparam logic [OP_W-1:0] ALU_SUB = 5'd1;
    localparam logic [OP_W-1:0] ALU_AND = 5'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 5'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 5'd4;
    localparam logic [OP_W-1:0] ALU_NOT = 5'd5;
    localparam logic [OP_W-1:0] ALU_INC = 5'd6;
    localparam logic [OP_W-1:0] ALU_DEC = 5'd7;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadA = 3'd1,
        StLoadB = 3'd2,
        StExec  = 3'd3,
        StDone  = 3'd4
    } state_t;

    // Binary ops occupy the low opcode range and need a second operand.
    function automatic logic is_binary_op(input logic [OP_W-1:0] op);
        return (op <= ALU_XOR);
    endfunction

endpackage

// File: rtl/alu_control_if.sv
// Signal bundle between the ALU sequencer and its environment
// (bus master + ALU).
//   master : environment side - drives start/op/bus_in and the ALU flags,
//            observes operands, select, enables, status and result.
//   slave  : sequencer side - the mirror image.
interface alu_control_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] bus_in;
    logic             alu_carry_out;
    logic             alu_zero;

    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [4:0]       alu_select;
    logic             alu_carry_in;
    logic             alu_enable;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] result;
    logic             carry_flag;
    logic             zero_flag;

    modport master (
        output start, op, bus_in, alu_carry_out, alu_zero,
        input  operand_a, operand_b, alu_select, alu_carry_in, alu_enable,
               busy, done, error, result, carry_flag, zero_flag
    );

    modport slave (
        input  start, op, bus_in, alu_carry_out, alu_zero,
        output operand_a, operand_b, alu_select, alu_carry_in, alu_enable,
               busy, done, error, result, carry_flag, zero_flag
    );

endinterface

// File: rtl/alu_control.sv
// ALU sequencer. Accepts an opcode on start, pulls operand A (and B for
// binary ops) off the shared data bus on successive cycles, lets the ALU
// drive the bus for one EXEC cycle, captures the result and flags, then
// pulses done for one cycle.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-high; aborts any operation, zeroes outputs
//   ctl   - alu_control_if.slave: start/op/bus_in/ALU flags in;
//           operands, select, carry-in, bus enable, status, result, flags out
// All status outputs are registered decodes of the next state so that
// alu_enable in particular cannot glitch.
module alu_control #(
    parameter int unsigned WIDTH  = alu_control_pkg::WIDTH,
    parameter int unsigned OP_MAX = 7
) (
    input logic          clk,
    input logic          reset,
    alu_control_if.slave ctl
);
    import alu_control_pkg::*;

    localparam logic [OP_W-1:0] OpMax = OP_W'(OP_MAX);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_err;
    logic             w_err_next;

    logic [WIDTH-1:0] r_operand_a;
    logic [WIDTH-1:0] r_operand_b;
    logic [OP_W-1:0]  r_alu_select;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_flag;
    logic             r_zero_flag;
    logic             r_alu_enable;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic             w_op_valid;
    logic             w_accept;

    assign w_op_valid = (ctl.op <= OpMax);
    assign w_accept   = (r_state == StIdle) && ctl.start && w_op_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= w_err_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. start is only looked at in IDLE, so requests that
    // arrive while busy are dropped rather than queued.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_err_next   = r_err;
        unique case (r_state)
            StIdle: begin
                if (ctl.start) begin
                    if (w_op_valid) begin
                        w_state_next = StLoadA;
                    end else begin
                        w_state_next = StDone;
                        w_err_next   = 1'b1;
                    end
                end
            end
            StLoadA: begin
                w_state_next = is_binary_op(r_alu_select) ? StLoadB : StExec;
            end
            StLoadB: begin
                w_state_next = StExec;
            end
            StExec: begin
                w_state_next = StDone;
            end
            StDone: begin
                w_state_next = StIdle;
                w_err_next   = 1'b0;
            end
            default: begin
                w_state_next = StIdle;
                w_err_next   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_operand_a  <= '0;
            r_operand_b  <= '0;
            r_alu_select <= '0;
            r_result     <= '0;
            r_carry_flag <= 1'b0;
            r_zero_flag  <= 1'b0;
            r_alu_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            // The select register doubles as the latched opcode; an invalid
            // request leaves it untouched.
            if (w_accept) begin
                r_alu_select <= ctl.op;
            end
            if (r_state == StLoadA) begin
                r_operand_a <= ctl.bus_in;
            end
            if (r_state == StLoadB) begin
                r_operand_b <= ctl.bus_in;
            end
            // In EXEC the ALU is driving bus_in, so the bus carries the result.
            if (r_state == StExec) begin
                r_result     <= ctl.bus_in;
                r_carry_flag <= ctl.alu_carry_out;
                r_zero_flag  <= ctl.alu_zero;
            end

            r_alu_enable <= (w_state_next == StExec);
            r_busy       <= (w_state_next == StLoadA) || (w_state_next == StLoadB) ||
                            (w_state_next == StExec);
            r_done       <= (w_state_next == StDone);
            r_error      <= (w_state_next == StDone) && w_err_next;
        end
    end

    assign ctl.operand_a    = r_operand_a;
    assign ctl.operand_b    = r_operand_b;
    assign ctl.alu_select   = r_alu_select;
    // Only add consumes the carry; the ALU ignores it for other opcodes.
    assign ctl.alu_carry_in = r_carry_flag;
    assign ctl.alu_enable   = r_alu_enable;
    assign ctl.busy         = r_busy;
    assign ctl.done         = r_done;
    assign ctl.error        = r_error;
    assign ctl.result       = r_result;
    assign ctl.carry_flag   = r_carry_flag;
    assign ctl.zero_flag    = r_zero_flag;

endmodule

// File: tb/tb_alu_control.sv
// Bench for alu_control: a behavioural 16-bit ALU on the far side of the bus,
// plus an integer-arithmetic reference model of the architectural state.
module tb_alu_control;
    import alu_control_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] r_drv_bus;
    logic [16:0] w_alu;

    int total = 0;
    int bad   = 0;

    // Reference architectural state
    logic [15:0] m_res, m_a, m_b;
    logic [4:0]  m_sel;
    logic        m_carry, m_zero;

    always #5 clk = ~clk;

    alu_control_if #(.WIDTH(16)) bif ();

    alu_control #(
        .WIDTH  (16),
        .OP_MAX (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bif)
    );

    // ALU: 17-bit result, drives the shared bus only while enabled.
    function automatic logic [16:0] alu_eval(input logic [4:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic cin);
        case (op)
            ALU_ADD: return {1'b0, a} + {1'b0, b} + {16'b0, cin};
            ALU_SUB: return {1'b0, a} - {1'b0, b};
            ALU_AND: return {1'b0, a & b};
            ALU_OR:  return {1'b0, a | b};
            ALU_XOR: return {1'b0, a ^ b};
            ALU_NOT: return {1'b0, ~a};
            ALU_INC: return {1'b0, a} + 17'd1;
            ALU_DEC: return {1'b0, a} - 17'd1;
            default: return 17'd0;
        endcase
    endfunction

    assign w_alu             = alu_eval(bif.alu_select, bif.operand_a, bif.operand_b,
                                        bif.alu_carry_in);
    assign bif.bus_in        = bif.alu_enable ? w_alu[15:0] : r_drv_bus;
    assign bif.alu_carry_out = w_alu[16];
    assign bif.alu_zero      = (w_alu[15:0] == 16'd0);

    // Reference: plain integer arithmetic from the opcode definitions.
    task automatic ref_op(input logic [4:0] op, input int a, input int b, input bit cin,
                          output logic [15:0] res, output logic cy);
        int r;
        r  = 0;
        cy = 1'b0;
        case (op)
            5'd0: begin r = a + b + int'(cin); cy = (r > 65535); end
            5'd1: begin r = a - b; cy = (a < b); end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = 65535 - a;
            5'd6: begin r = a + 1; cy = (a == 65535); end
            5'd7: begin r = a - 1; cy = (a == 0); end
            default: r = 0;
        endcase
        res = 16'(r);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_operand_a"}, 32'(bif.operand_a), 32'd0);
        chk({pfx, "_operand_b"}, 32'(bif.operand_b), 32'd0);
        chk({pfx, "_alu_select"}, 32'(bif.alu_select), 32'd0);
        chk({pfx, "_result"}, 32'(bif.result), 32'd0);
        chk({pfx, "_flags"}, 32'({bif.carry_flag, bif.zero_flag, bif.alu_carry_in}), 32'd0);
        chk({pfx, "_status"}, 32'({bif.alu_enable, bif.busy, bif.done, bif.error}), 32'd0);
    endtask

    // One request from IDLE to completion, then one more edge back into IDLE.
    // With hold set, start stays high and op is scrambled every cycle.
    task automatic do_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input bit hold);
        int done_cyc, en_cnt, en_cyc;
        logic err_seen;
        bit valid, bin;
        logic [15:0] e_res;
        logic e_cy;
        valid    = (op <= 5'd7);
        bin      = (op <= 5'd4);
        done_cyc = 0;
        en_cnt   = 0;
        en_cyc   = 0;
        err_seen = 1'b0;

        bif.start = 1'b1;
        bif.op    = op;
        r_drv_bus = a;
        @(posedge clk); #1;
        if (!hold) bif.start = 1'b0;
        for (int c = 1; c <= 8 && done_cyc == 0; c++) begin
            if (hold) bif.op = 5'($urandom_range(0, 31));
            r_drv_bus = (c == 1) ? a : (c == 2) ? b : 16'($urandom);
            if (bif.alu_enable) begin
                en_cnt++;
                en_cyc = c;
            end
            if (bif.done) begin
                done_cyc = c;
                err_seen = bif.error;
            end
            if (done_cyc == 0) begin
                @(posedge clk); #1;
            end
        end

        if (valid) begin
            ref_op(op, int'(a), int'(b), m_carry, e_res, e_cy);
            m_res   = e_res;
            m_carry = e_cy;
            m_zero  = (e_res == 16'd0);
            m_a     = a;
            m_sel   = op;
            if (bin) m_b = b;
        end

        chk("done_cycle", 32'(done_cyc), valid ? (bin ? 32'd4 : 32'd3) : 32'd1);
        chk("enable_count", 32'(en_cnt), valid ? 32'd1 : 32'd0);
        chk("enable_cycle", 32'(en_cyc), valid ? (bin ? 32'd3 : 32'd2) : 32'd0);
        chk("error", 32'(err_seen), 32'(!valid));
        chk("busy_in_done", 32'(bif.busy), 32'd0);
        chk("result", 32'(bif.result), 32'(m_res));
        chk("carry_flag", 32'(bif.carry_flag), 32'(m_carry));
        chk("zero_flag", 32'(bif.zero_flag), 32'(m_zero));
        chk("alu_carry_in", 32'(bif.alu_carry_in), 32'(m_carry));
        chk("operand_a", 32'(bif.operand_a), 32'(m_a));
        chk("operand_b", 32'(bif.operand_b), 32'(m_b));
        chk("alu_select", 32'(bif.alu_select), 32'(m_sel));

        @(posedge clk); #1;
        chk("done_one_cycle", 32'({bif.done, bif.error}), 32'd0);
        chk("idle_not_busy", 32'(bif.busy), 32'd0);
    endtask

    initial begin
        int done_seen;
        logic [4:0] rop;
        logic [15:0] ra, rb;

        reset     = 1'b1;
        bif.start = 1'b0;
        bif.op    = 5'd0;
        r_drv_bus = 16'd0;
        m_res = 16'd0; m_a = 16'd0; m_b = 16'd0; m_sel = 5'd0;
        m_carry = 1'b0; m_zero = 1'b0;

        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Add chain: second add consumes the carry left by the first.
        do_op(ALU_ADD, 16'hFFFF, 16'h0001, 1'b0);
        chk("add1_result", 32'(bif.result), 32'h0000);
        chk("add1_carry", 32'(bif.carry_flag), 32'd1);
        do_op(ALU_ADD, 16'h0001, 16'h0001, 1'b0);
        chk("add2_result", 32'(bif.result), 32'h0003);

        // Borrow
        do_op(ALU_SUB, 16'h0003, 16'h0005, 1'b0);
        chk("sub_result", 32'({bif.result, bif.carry_flag, bif.zero_flag}), 32'({16'hFFFE, 2'b10}));

        // Unary ops keep operand_b
        do_op(ALU_INC, 16'hFFFF, 16'h1357, 1'b0);
        chk("inc_result", 32'({bif.result, bif.carry_flag, bif.zero_flag}), 32'({16'h0000, 2'b11}));
        chk("inc_opb_kept", 32'(bif.operand_b), 32'h0005);
        do_op(ALU_NOT, 16'h00FF, 16'h2468, 1'b0);
        chk("not_result", 32'(bif.result), 32'hFF00);
        do_op(ALU_DEC, 16'h0000, 16'h0000, 1'b0);
        chk("dec_result", 32'({bif.result, bif.carry_flag}), 32'({16'hFFFF, 1'b1}));

        // Invalid opcode
        do_op(5'd9, 16'hAAAA, 16'h5555, 1'b0);

        // start held high with op changing: only the first opcode runs, and the
        // next request is taken in the cycle right after done.
        do_op(ALU_XOR, 16'hF0F0, 16'h3C3C, 1'b1);
        do_op(ALU_AND, 16'hF0F0, 16'h3C3C, 1'b0);

        // Asynchronous reset in the middle of LOAD_B
        bif.start = 1'b1;
        bif.op    = ALU_SUB;
        r_drv_bus = 16'h1234;
        @(posedge clk); #1;
        bif.start = 1'b0;
        r_drv_bus = 16'h5678;
        @(posedge clk); #1;
        chk("pre_reset_busy", 32'(bif.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("midop_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bif.done || bif.busy || bif.alu_enable) done_seen++;
            @(posedge clk); #1;
        end
        chk("no_done_after_reset", 32'(done_seen), 32'd0);
        m_res = 16'd0; m_a = 16'd0; m_b = 16'd0; m_sel = 5'd0;
        m_carry = 1'b0; m_zero = 1'b0;

        // Randomized traffic with occasional boundary operands and bad opcodes
        for (int n = 0; n < 24; n++) begin
            rop = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31))
                                              : 5'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            do_op(rop, ra, rb, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_control.md
# alu_control

Sequencer directly upstream of the 16-bit ALU. Accepts an operation request, collects operands from the shared 16-bit data bus over successive cycles, and drives the ALU's operand, select, carry-in and bus-enable inputs. It then captures the ALU result and flags into architectural registers and reports completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `WIDTH`, 16, data/operand width; must match the ALU.
- `OP_MAX`, 7, highest valid opcode; opcodes above this are errors.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  5  opcode, sampled with `start`: 0 add-with-carry, 1 sub, 2 and, 3 or, 4 xor, 5 not, 6 inc, 7 dec.
- `bus_in`  in  16  shared data bus (read side).
- `alu_carry_out`  in  1  ALU carry out (bit 16 of the ALU result).
- `alu_zero`  in  1  ALU zero flag.
- `operand_a`  out  16  ALU `in_1`, registered.
- `operand_b`  out  16  ALU `in_2`, registered.
- `alu_select`  out  5  ALU select, registered copy of latched `op`.
- `alu_carry_in`  out  1  equals `carry_flag`.
- `alu_enable`  out  1  ALU bus drive enable; high only in EXEC.
- `busy`  out  1  high in LOAD_A, LOAD_B and EXEC.
- `done`  out  1  one-cycle pulse in DONE.
- `error`  out  1  high with `done` when the opcode was invalid.
- `result`  out  16  last captured result.
- `carry_flag`  out  1  last captured carry.
- `zero_flag`  out  1  last captured zero.

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, DONE.
- IDLE:
  - `start`=1 and `op`≤OP_MAX: latch `op`, go to LOAD_A.
  - `start`=1 and `op`>OP_MAX: set the error latch, go to DONE. Operands, result and flags are unchanged.
- LOAD_A: the edge captures `bus_in` into `operand_a`.
  - Binary ops (0–4) go to LOAD_B.
  - Unary ops (5–7) go to EXEC. `operand_b` keeps its previous value, and the ALU ignores it.
- LOAD_B: the edge captures `bus_in` into `operand_b`, then go to EXEC.
- EXEC:
  - `alu_enable`=1, so the ALU drives the bus.
  - The edge captures `bus_in` into `result`, `alu_carry_out` into `carry_flag`, and `alu_zero` into `zero_flag`.
  - Then go to DONE.
- DONE: `done`=1, and `error` reflects the error latch. Go to IDLE and clear the error latch.
- `start` outside IDLE is ignored; requests are not queued.
- Arithmetic widths follow the ALU's 17-bit result.
  - Sub borrow: `carry_flag`=1 when A<B.
  - inc of 0xFFFF gives 0x0000 with carry=1.
  - dec of 0x0000 gives 0xFFFF with carry=1.
- Add uses the stored `carry_flag` as carry in. No other op reads it.
- Reset (asynchronous, any state, including mid-operation):
  - State returns to IDLE and the operation is aborted; no `done` is issued.
  - All outputs go to 0, including `operand_a`, `operand_b`, `alu_select`, `result`, the flags and `alu_enable`.

## Timing
- Cycle 0 is the edge at which `start` is sampled in IDLE.
- Binary ops:
  - LOAD_A in cycle 1, so the bus master presents A in cycle 1.
  - LOAD_B in cycle 2, so B is presented in cycle 2.
  - EXEC in cycle 3.
  - `done` in cycle 4. Latency is 4 cycles.
- Unary ops: LOAD_A in cycle 1, EXEC in cycle 2, `done` in cycle 3.
- Invalid ops: `done` and `error` in cycle 1.
- Earliest next accepted `start` is the cycle after DONE, so throughput is 5 cycles per binary op.
- `alu_enable` is a registered state decode and must be glitch-free: exactly one cycle high per valid op, never high in reset.
- The bus master must not drive `bus_in` while `alu_enable`=1.
- `result` and the flags update at the EXEC→DONE edge, so they are valid while `done`=1.

## Structure
- Shared package or header `alu_defs`:
  - opcode constants `ALU_ADD`…`ALU_DEC` (0–7);
  - state encoding constants;
  - `WIDTH`.
- The ALU itself must also use the `alu_defs` opcode constants.
- No sub-module. It is a single FSM plus datapath registers.

## Test plan
- Reset: assert `reset` mid-LOAD_B. All outputs are 0 immediately (asynchronous), state is IDLE, and no `done` follows.
- Add chain:
  - Starting from `carry_flag`=0, run add 0xFFFF+0x0001: `result`=0x0000, carry=1, zero=1, `done` at cycle 4.
  - Then add 0x0001+0x0001: `result`=0x0003, because the stored carry is used.
- Sub borrow: sub 0x0003−0x0005 gives `result`=0xFFFE, carry=1, zero=0. `alu_enable` is high for exactly one cycle (cycle 3).
- Unary:
  - inc 0xFFFF gives 0x0000, carry=1, zero=1, `done` at cycle 3.
  - not 0x00FF gives 0xFF00.
  - `operand_b` is unchanged in both cases.
- Invalid op: `op`=9 gives `done` and `error` in cycle 1. `result` and flags are unchanged, and `alu_enable` never rises.
- Ignored start: hold `start`=1 throughout a binary op with `op` changing each cycle. Only the first opcode executes, and a new op is accepted the cycle after `done`.
